// File: rtl/hawk_tbl_init_mngr.sv
// hawk_tbl_init_mngr: table-initialisation write engine for the HAWK page
// manager. On a start strobe it fills the ATT region (zeros), the list region
// (one doubly-linked free list) or an arbitrary block range (zeros) using
// single-beat DATA_W-bit AXI4 writes, with up to MAX_OUTSTANDING writes
// awaiting a B response.
//
// Ports:
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   start_i, mode_i               command strobe and mode (0 ATT, 1 LIST, 2 ZERO, 3 reserved)
//   zf_base_i, zf_blocks_i        ZERO_FILL base address and block count
//   aw*/w*/b*                     AXI4 write address / data / response channels
//   busy_o, done_o, err_o         command in progress, completion pulse, sticky error

// One 16-byte free-list entry. idx is the 1-based entry number; idx 0 or
// beyond LIST_ENTRIES produces an all-zero (unstrobed) lane.
module hawk_tbl_list_lane #(
  parameter int unsigned LIST_ENTRIES = 10,
  parameter logic [47:0] PPA_START    = 48'h0
) (
  input  logic [31:0]  idx,
  output logic [127:0] entry
);
  always_comb begin
    entry = '0;
    if (idx != 32'd0 && idx <= 32'(LIST_ENTRIES)) begin
      entry[31:0]   = (idx == 32'(LIST_ENTRIES)) ? 32'd0 : idx + 32'd1;
      entry[63:32]  = idx - 32'd1;
      entry[111:64] = PPA_START + 48'(idx - 32'd1);
    end
  end
endmodule

module hawk_tbl_init_mngr #(
  parameter int unsigned ADDR_W          = 64,
  parameter int unsigned DATA_W          = 512,
  parameter logic [63:0] ATT_BASE        = 64'h0,
  parameter int unsigned ATT_ENTRIES     = 64,
  parameter int unsigned ATT_ENTRY_BYTES = 8,
  parameter logic [63:0] LIST_BASE       = 64'h200,
  parameter int unsigned LIST_ENTRIES    = 10,
  parameter logic [47:0] PPA_START       = 48'h0,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [1:0]          mode_i,
  input  logic [ADDR_W-1:0]   zf_base_i,
  input  logic [15:0]         zf_blocks_i,
  output logic                awvalid_o,
  output logic [ADDR_W-1:0]   awaddr_o,
  input  logic                awready_i,
  output logic                wvalid_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic                wlast_o,
  input  logic                wready_i,
  input  logic                bvalid_i,
  input  logic [1:0]          bresp_i,
  output logic                bready_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);
  localparam int unsigned BLK_BYTES  = DATA_W / 8;
  localparam int unsigned LANES      = DATA_W / 128;
  localparam int unsigned ATT_BYTES  = ATT_ENTRIES * ATT_ENTRY_BYTES;
  localparam int unsigned LIST_BYTES = LIST_ENTRIES * 16;
  localparam logic [15:0] ATT_NB     = 16'((ATT_BYTES + BLK_BYTES - 1) / BLK_BYTES);
  localparam logic [15:0] LIST_NB    = 16'((LIST_BYTES + BLK_BYTES - 1) / BLK_BYTES);

  localparam logic [1:0] MODE_ATT  = 2'd0;
  localparam logic [1:0] MODE_LIST = 2'd1;
  localparam logic [1:0] MODE_ZERO = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t              state, state_nxt;
  logic [1:0]          mode_q;
  logic [ADDR_W-1:0]   base_q, start_base;
  logic [15:0]         nb_q, start_nb;
  logic [15:0]         aw_cnt, w_cnt, b_cnt, outstanding;
  logic                accept, aw_hs, w_hs, b_hs;

  assign accept      = (state == IDLE) && start_i;
  assign aw_hs       = awvalid_o && awready_i;
  assign w_hs        = wvalid_o && wready_i;
  assign b_hs        = bvalid_i && bready_o;
  assign outstanding = aw_cnt - b_cnt;

  // Region base and block count implied by the incoming command.
  always_comb begin
    start_nb   = 16'd0;
    start_base = '0;
    case (mode_i)
      MODE_ATT:  begin start_nb = ATT_NB;      start_base = ADDR_W'(ATT_BASE);  end
      MODE_LIST: begin start_nb = LIST_NB;     start_base = ADDR_W'(LIST_BASE); end
      MODE_ZERO: begin start_nb = zf_blocks_i; start_base = zf_base_i;          end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; empty or reserved commands complete without traffic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_i)
               state_nxt = (mode_i == MODE_RSVD || start_nb == 16'd0) ? DONE : ISSUE;
      ISSUE: if (aw_cnt == nb_q && w_cnt == nb_q) state_nxt = DRAIN;
      DRAIN: if (b_cnt == nb_q) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs. AW valid is a pure function of counters so it never depends on
  // ready; W trails AW so data for block k only follows acceptance of AW k.
  always_comb begin
    busy_o    = (state == ISSUE) || (state == DRAIN);
    done_o    = (state == DONE);
    awvalid_o = (state == ISSUE) && (aw_cnt < nb_q) &&
                (outstanding < 16'(MAX_OUTSTANDING));
    wvalid_o  = busy_o && (w_cnt < aw_cnt);
  end

  assign bready_o = busy_o;
  assign wlast_o  = 1'b1;
  assign awaddr_o = base_q + ADDR_W'(aw_cnt) * ADDR_W'(BLK_BYTES);

  // Counters, command registers and sticky error
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mode_q <= MODE_ATT;
      base_q <= '0;
      nb_q   <= '0;
      aw_cnt <= '0;
      w_cnt  <= '0;
      b_cnt  <= '0;
      err_o  <= 1'b0;
    end else if (accept) begin
      mode_q <= mode_i;
      base_q <= start_base;
      nb_q   <= start_nb;
      aw_cnt <= '0;
      w_cnt  <= '0;
      b_cnt  <= '0;
      err_o  <= (mode_i == MODE_RSVD);
    end else begin
      if (aw_hs) aw_cnt <= aw_cnt + 16'd1;
      if (w_hs)  w_cnt  <= w_cnt + 16'd1;
      if (b_hs)  b_cnt  <= b_cnt + 16'd1;
      if (b_hs && bresp_i != 2'b00) err_o <= 1'b1;
    end
  end

  // Write payload for block w_cnt. Strobes cover only bytes inside the region,
  // which trims the tail block of ATT and LIST fills.
  logic [LANES-1:0][127:0] list_data;
  logic [31:0]             blk_byte0, limit;

  assign blk_byte0 = 32'(w_cnt) * 32'(BLK_BYTES);

  always_comb begin
    case (mode_q)
      MODE_ATT:  limit = 32'(ATT_BYTES);
      MODE_LIST: limit = 32'(LIST_BYTES);
      default:   limit = '1;
    endcase
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [31:0] idx;
    assign idx = 32'(w_cnt) * 32'(LANES) + 32'(j) + 32'd1;
    hawk_tbl_list_lane #(
      .LIST_ENTRIES (LIST_ENTRIES),
      .PPA_START    (PPA_START)
    ) u_lane (
      .idx   (idx),
      .entry (list_data[j])
    );
  end

  for (genvar b = 0; b < BLK_BYTES; b++) begin : g_strb
    assign wstrb_o[b] = (blk_byte0 + 32'(b)) < limit;
  end

  assign wdata_o = (mode_q == MODE_LIST) ? list_data : '0;

endmodule
